// File: rtl/jtpang_objdma_if.sv
// CPU bus-request link plus VRAM source and object line-buffer destination ports of the
// object DMA engine. master = DMA engine side, slave = CPU / memories side.
interface jtpang_objdma_if #(
    parameter int unsigned AW = 12
) ();
    logic          dma_go;
    logic          busrq_n;
    logic          busak_n;
    logic [AW-1:0] vram_addr;
    logic          vram_msb;
    logic [7:0]    vram_dout;
    logic [AW-1:0] obj_addr;
    logic [7:0]    obj_din;
    logic          obj_we;

    modport master (
        input  dma_go, busak_n, vram_dout,
        output busrq_n, vram_addr, vram_msb, obj_addr, obj_din, obj_we
    );

    modport slave (
        output dma_go, busak_n, vram_dout,
        input  busrq_n, vram_addr, vram_msb, obj_addr, obj_din, obj_we
    );
endinterface

// File: rtl/jtpang_objdma.sv
// Object DMA: holds the Z80 off the bus and copies LEN bytes from upper-bank VRAM into the
// object line buffer. Define JTPANG_DMA_PEND_EN to queue one go edge seen while busy.
module jtpang_objdma #(
    parameter int unsigned   AW  = 12,
    parameter logic [AW-1:0] SRC = '0,
    parameter int unsigned   LEN = 12'h800
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cen,
    jtpang_objdma_if.master    bus,
    output logic               busy,
    output logic               done
);
    typedef enum logic [2:0] {StIdle, StReq, StCopy, StFlush, StRel} state_t;

    localparam logic [AW:0]   LAST    = (AW+1)'(LEN - 1);
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADR_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_q;
    logic [AW:0]   cnt_q;
    logic          go_q;
    logic          rd_q;
    logic          busrq_q;
    logic          busy_q;
    logic          done_q;
    logic          msb_q;
    logic          we_q;
    logic [AW-1:0] vaddr_q;
    logic [AW-1:0] oaddr_q;
`ifdef JTPANG_DMA_PEND_EN
    logic          pend_q;
`endif

    logic go_edge;
    assign go_edge = bus.dma_go & ~go_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            go_q    <= 1'b0;
            rd_q    <= 1'b0;
            busrq_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            msb_q   <= 1'b0;
            we_q    <= 1'b0;
            vaddr_q <= '0;
            oaddr_q <= '0;
`ifdef JTPANG_DMA_PEND_EN
            pend_q  <= 1'b0;
`endif
        end else if (cen) begin
            go_q   <= bus.dma_go;
            done_q <= 1'b0;
            rd_q   <= 1'b0;
            // Write stage: the byte addressed last cen is on vram_dout now.
            we_q   <= rd_q;
            if (rd_q) oaddr_q <= cnt_q[AW-1:0] - ADR_ONE;
`ifdef JTPANG_DMA_PEND_EN
            if (go_edge && state_q != StIdle) pend_q <= 1'b1;
`endif
            case (state_q)
                StIdle: begin
                    if (go_edge) begin
                        state_q <= StReq;
                        busrq_q <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                StReq: begin
                    busrq_q <= 1'b0;
                    busy_q  <= 1'b1;
                    cnt_q   <= '0;
                    if (!bus.busak_n) begin
                        state_q <= StCopy;
                        msb_q   <= 1'b1;
                    end
                end
                StCopy: begin
                    // Losing the ack pauses the read stage only; cnt holds.
                    if (!bus.busak_n) begin
                        vaddr_q <= SRC + cnt_q[AW-1:0];
                        cnt_q   <= cnt_q + CNT_ONE;
                        rd_q    <= 1'b1;
                        if (cnt_q == LAST) state_q <= StFlush;
                    end
                end
                StFlush: begin
                    state_q <= StRel;
                    msb_q   <= 1'b0;
                end
                StRel: begin
                    busrq_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    cnt_q   <= '0;
`ifdef JTPANG_DMA_PEND_EN
                    if (pend_q || go_edge) begin
                        state_q <= StReq;
                        pend_q  <= 1'b0;
                    end else begin
                        state_q <= StIdle;
                    end
`else
                    state_q <= StIdle;
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busrq_n   = busrq_q;
    assign bus.vram_addr = vaddr_q;
    assign bus.vram_msb  = msb_q;
    assign bus.obj_addr  = oaddr_q;
    assign bus.obj_din   = bus.vram_dout;
    assign bus.obj_we    = we_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule
